// File: rtl/wb_retire_buf.sv
// wb_retire_buf: DEPTH-entry in-order retire buffer between MEM and the
// register file. It absorbs results while the RF port is stalled and retires
// at most one entry per cycle. An excepting or ERET head entry raises a
// one-cycle pipeline flush. Buffered results are forwarded to ID, with the
// youngest matching entry winning.
module wb_retire_buf #(
    parameter int          DEPTH      = 4,
    parameter int          NUM_EXC    = 8,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_to_ws_valid,
    output logic                       ws_allowin,
    input  logic [31:0]                in_pc,
    input  logic                       in_gpr_we,
    input  logic [4:0]                 in_dest,
    input  logic [31:0]                in_result,
    input  logic [NUM_EXC-1:0]         in_exc,
    input  logic                       in_eret,
    input  logic                       in_cancel,
    input  logic                       rf_stall,
    input  logic [31:0]                epc_in,
    input  logic [4:0]                 hz_raddr,
    output logic                       hz_hit,
    output logic [31:0]                hz_data,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic                       exc_flush,
    output logic [31:0]                ws_pc_gen_exc,
    output logic [$clog2(NUM_EXC)-1:0] exc_code,
    output logic [$clog2(DEPTH):0]     ws_count,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = $clog2(NUM_EXC);

    // Entry storage. Validity comes from the head/count window, so the
    // payload arrays need no reset.
    logic [31:0]        pc_q     [DEPTH];
    logic               we_q     [DEPTH];
    logic [4:0]         dest_q   [DEPTH];
    logic [31:0]        res_q    [DEPTH];
    logic [NUM_EXC-1:0] exc_q    [DEPTH];
    logic               eret_q   [DEPTH];
    logic               cancel_q [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          push, retire, flush, wr;
    logic          h_exc, h_eret, h_cancel;
    logic [EW-1:0] h_code;
    logic [PW-1:0] fwd_idx;

    assign h_exc    = |exc_q[head_q];
    assign h_eret   = eret_q[head_q];
    assign h_cancel = cancel_q[head_q];

    assign retire = (count_q != '0) && !rf_stall;
    // Cancelled entries retire silently, even when they carry exception causes.
    assign flush  = retire && !h_cancel && (h_exc || h_eret);
    assign wr     = retire && !h_cancel && !h_exc && !h_eret && we_q[head_q];

    // A full buffer never accepts, even in a cycle that retires.
    assign ws_allowin = (count_q != CW'(DEPTH)) && !flush;
    assign push       = ms_to_ws_valid && ws_allowin;

    // Priority encode the head's cause vector; bit 0 has the highest priority.
    always_comb begin
        h_code = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (exc_q[head_q][i]) h_code = EW'(i);
        end
    end

    // Walk the buffer from oldest to youngest so that the last match is the youngest one.
    always_comb begin
        hz_hit  = 1'b0;
        hz_data = '0;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && !cancel_q[fwd_idx] && we_q[fwd_idx] &&
                (dest_q[fwd_idx] == hz_raddr) && (hz_raddr != '0)) begin
                hz_hit  = 1'b1;
                hz_data = res_q[fwd_idx];
            end
        end
    end

    // Pointer and occupancy next state. A flush discards everything behind the head.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push)   tail_d = tail_q + PW'(1);
            if (retire) head_d = head_q + PW'(1);
            if (push && !retire)      count_d = count_q + CW'(1);
            else if (!push && retire) count_d = count_q - CW'(1);
        end
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write the accepted MEM-stage entry into the tail slot.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_q[tail_q]     <= in_pc;
            we_q[tail_q]     <= in_gpr_we;
            dest_q[tail_q]   <= in_dest;
            res_q[tail_q]    <= in_result;
            exc_q[tail_q]    <= in_exc;
            eret_q[tail_q]   <= in_eret;
            cancel_q[tail_q] <= in_cancel;
        end
    end

    assign rf_we         = wr;
    assign rf_waddr      = wr ? dest_q[head_q] : '0;
    assign rf_wdata      = wr ? res_q[head_q] : '0;
    assign exc_flush     = flush;
    assign ws_pc_gen_exc = flush ? (h_exc ? EXC_VECTOR : epc_in) : '0;
    assign exc_code      = (flush && h_exc) ? h_code : '0;
    assign ws_count      = count_q;

    assign debug_wb_pc       = wr ? pc_q[head_q] : '0;
    assign debug_wb_rf_wen   = {4{wr}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
endmodule
